kong_motion_ctrl: RTL and testbench

//  Sequences the Kong sprite renderer: drives its position, animation frame and visibility.

---
 rtl/kong_motion_ctrl_pkg.sv | 45 ++++
 rtl/kong_motion_ctrl_if.sv | 24 ++
 rtl/kong_motion_ctrl_frame_tick_gen.sv | 24 ++
 rtl/kong_motion_ctrl.sv | 147 ++++++++++++++
 tb/tb_kong_motion_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kong_motion_ctrl_pkg.sv
// Shared Kong motion types: FSM encoding, screen geometry and the clamped patrol step.
package kong_motion_ctrl_pkg;

  localparam int SCREEN_W = 640;
  localparam int KONG_W   = 177;
  localparam int KONG_H   = 117;

  localparam logic [1:0] ST_HIDDEN = 2'd0;
  localparam logic [1:0] ST_WALK   = 2'd1;
  localparam logic [1:0] ST_BEAT   = 2'd2;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef struct packed {
    logic [9:0] x;
    logic       dir;
  } kong_pos_t;

  // Bound tests are done on 11 bits so neither posx + step nor x_min + step can wrap.
  function automatic kong_pos_t kong_walk_step(input kong_pos_t  cur,
                                               input logic [9:0] x_min,
                                               input logic [9:0] x_max,
                                               input logic [9:0] step);
    kong_pos_t nxt;
    nxt = cur;
    if (cur.dir == DIR_RIGHT) begin
      if (({1'b0, cur.x} + {1'b0, step}) >= {1'b0, x_max}) begin
        nxt.x   = x_max;
        nxt.dir = DIR_LEFT;
      end else begin
        nxt.x = cur.x + step;
      end
    end else begin
      if ({1'b0, cur.x} <= ({1'b0, x_min} + {1'b0, step})) begin
        nxt.x   = x_min;
        nxt.dir = DIR_RIGHT;
      end else begin
        nxt.x = cur.x - step;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/kong_motion_ctrl_if.sv
// Game-state inputs and sprite-renderer outputs of the Kong motion controller.
interface kong_motion_ctrl_if;

  logic [8:0] y;
  logic       enable;
  logic       pause;
  logic       kill;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       animation_state;
  logic       isplay;
  logic       barrel_spawn;

  modport master (
    output y, enable, pause, kill,
    input  posx, posy, animation_state, isplay, barrel_spawn
  );

  modport slave (
    input  y, enable, pause, kill,
    output posx, posy, animation_state, isplay, barrel_spawn
  );

endinterface

// File: rtl/kong_motion_ctrl_frame_tick_gen.sv
// One-cycle frame tick in the cycle where the scan row leaves TICK_LINE.
// Tick is combinational from a registered "on the line" flag; no backpressure.
module kong_motion_ctrl_frame_tick_gen #(
  parameter int TICK_LINE = 479
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] y,
  output logic       tick
);

  logic on_line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_line_q <= 1'b0;
    end else begin
      on_line_q <= (y == 9'(TICK_LINE));
    end
  end

  assign tick = on_line_q & (y != 9'(TICK_LINE));

endmodule

// File: rtl/kong_motion_ctrl.sv
// Kong patrol/beat sequencer: one state update per effective frame tick, visible one clk after the tick.
// Single-cycle barrel_spawn pulse on BEAT exit; kill overrides everything; no backpressure.
module kong_motion_ctrl
  import kong_motion_ctrl_pkg::*;
#(
  parameter int TICK_LINE   = 479,
  parameter int X_START     = 0,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = SCREEN_W - KONG_W,
  parameter int Y_POS       = 40,
  parameter int STEP        = 2,
  parameter int ANIM_DIV    = 8,
  parameter int BEAT_DIV    = 4,
  parameter int WALK_FRAMES = 120,
  parameter int BEAT_FRAMES = 60
) (
  input logic               clk,
  input logic               rst_n,
  kong_motion_ctrl_if.slave bus
);

  localparam int AW = $clog2(((ANIM_DIV > BEAT_DIV) ? ANIM_DIV : BEAT_DIV) + 1);
  localparam int WW = $clog2(WALK_FRAMES + 1);
  localparam int BW = $clog2(BEAT_FRAMES + 1);

  logic          tick;
  logic          eff_tick;
  logic [1:0]    state_q, state_d;
  kong_pos_t     pos_q, pos_d, pos_step;
  logic          anim_q, anim_d;
  logic [AW-1:0] anim_cnt_q, anim_cnt_d;
  logic [WW-1:0] walk_cnt_q, walk_cnt_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          isplay_q;
  logic          spawn_q, spawn_d;

  kong_motion_ctrl_frame_tick_gen #(
    .TICK_LINE (TICK_LINE)
  ) u_frame_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .y     (bus.y),
    .tick  (tick)
  );

  assign eff_tick = tick & bus.enable & ~bus.pause;

  // The tick that leaves HIDDEN already takes the first rightward step.
  always_comb begin
    kong_pos_t walk_from;
    walk_from = pos_q;
    if (state_q == ST_HIDDEN) begin
      walk_from.dir = DIR_RIGHT;
    end
    pos_step = kong_walk_step(walk_from, 10'(X_MIN), 10'(X_MAX), 10'(STEP));
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    anim_d     = anim_q;
    anim_cnt_d = anim_cnt_q;
    walk_cnt_d = walk_cnt_q;
    beat_cnt_d = beat_cnt_q;
    spawn_d    = 1'b0;

    if (bus.kill) begin
      state_d    = ST_HIDDEN;
      pos_d.x    = 10'(X_START);
      pos_d.dir  = DIR_RIGHT;
      anim_d     = 1'b0;
      anim_cnt_d = '0;
      walk_cnt_d = '0;
      beat_cnt_d = '0;
    end else if (eff_tick) begin
      case (state_q)
        ST_HIDDEN, ST_WALK: begin
          state_d = ST_WALK;
          pos_d   = pos_step;
          if (anim_cnt_q == AW'(ANIM_DIV - 1)) begin
            anim_d     = ~anim_q;
            anim_cnt_d = '0;
          end else begin
            anim_cnt_d = anim_cnt_q + 1'b1;
          end
          // The anim phase restarts so BEAT toggles on its own BEAT_DIV grid.
          if (walk_cnt_q == WW'(WALK_FRAMES - 1)) begin
            state_d    = ST_BEAT;
            walk_cnt_d = '0;
            anim_cnt_d = '0;
          end else begin
            walk_cnt_d = walk_cnt_q + 1'b1;
          end
        end
        ST_BEAT: begin
          if (anim_cnt_q == AW'(BEAT_DIV - 1)) begin
            anim_d     = ~anim_q;
            anim_cnt_d = '0;
          end else begin
            anim_cnt_d = anim_cnt_q + 1'b1;
          end
          if (beat_cnt_q == BW'(BEAT_FRAMES - 1)) begin
            state_d    = ST_WALK;
            beat_cnt_d = '0;
            anim_cnt_d = '0;
            spawn_d    = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_HIDDEN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HIDDEN;
      pos_q.x    <= 10'(X_START);
      pos_q.dir  <= DIR_RIGHT;
      anim_q     <= 1'b0;
      anim_cnt_q <= '0;
      walk_cnt_q <= '0;
      beat_cnt_q <= '0;
      isplay_q   <= 1'b0;
      spawn_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      anim_q     <= anim_d;
      anim_cnt_q <= anim_cnt_d;
      walk_cnt_q <= walk_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      isplay_q   <= (state_d != ST_HIDDEN);
      spawn_q    <= spawn_d;
    end
  end

  assign bus.posx            = pos_q.x;
  assign bus.posy            = 9'(Y_POS);
  assign bus.animation_state = anim_q;
  assign bus.isplay          = isplay_q;
  assign bus.barrel_spawn    = spawn_q;

endmodule

// File: tb/tb_kong_motion_ctrl.sv
// Self-checking bench for kong_motion_ctrl: vector table, directed corner sequences, random run vs reference model.
module tb_kong_motion_ctrl;

  localparam int LINE = 479;
  localparam int XMAX = 463;
  localparam int YPOS = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  kong_motion_ctrl_if bus ();

  kong_motion_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: game-level view of Kong (visible, beating, heading right, frames into current phase).
  bit m_vis, m_beating, m_right, m_anim, m_spawn, m_on_line;
  int m_posx, m_walk_n, m_beat_n;

  // Run statistics.
  int spawn_seen, posx_max, min_after_right, out_of_range;
  bit hit_right;

  typedef struct {
    int y;
    bit en, pz, kl;
    int ex_posx;
    bit ex_vis, ex_anim, ex_spawn;
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vis = 0; m_beating = 0; m_right = 1; m_anim = 0; m_spawn = 0; m_on_line = 0;
    m_posx = 0; m_walk_n = 0; m_beat_n = 0;
  endtask

  task automatic model_step(input int yv, input bit en, input bit pz, input bit kl);
    bit tick;
    tick      = m_on_line && (yv != LINE);
    m_on_line = (yv == LINE);
    m_spawn   = 0;
    if (kl) begin
      m_vis = 0; m_beating = 0; m_right = 1; m_anim = 0;
      m_posx = 0; m_walk_n = 0; m_beat_n = 0;
      return;
    end
    if (!(tick && en && !pz)) return;
    if (!m_vis) begin
      m_vis   = 1;
      m_right = 1;
    end
    if (m_beating) begin
      m_beat_n++;
      if (m_beat_n % 4 == 0) m_anim = !m_anim;
      if (m_beat_n == 60) begin
        m_beating = 0;
        m_walk_n  = 0;
        m_spawn   = 1;
      end
    end else begin
      if (m_right) begin
        m_posx = m_posx + 2;
        if (m_posx >= XMAX) begin m_posx = XMAX; m_right = 0; end
      end else begin
        m_posx = m_posx - 2;
        if (m_posx <= 0) begin m_posx = 0; m_right = 1; end
      end
      m_walk_n++;
      if (m_walk_n % 8 == 0) m_anim = !m_anim;
      if (m_walk_n == 120) begin
        m_beating = 1;
        m_beat_n  = 0;
      end
    end
  endtask

  task automatic drive(input int yv, input bit en, input bit pz, input bit kl);
    bus.y      = 9'(yv);
    bus.enable = en;
    bus.pause  = pz;
    bus.kill   = kl;
    model_step(yv, en, pz, kl);
  endtask

  task automatic cyc(input int yv, input bit en, input bit pz, input bit kl);
    drive(yv, en, pz, kl);
    @(negedge clk);
    check("model.posx",   int'(bus.posx), m_posx);
    check("model.posy",   int'(bus.posy), YPOS);
    check("model.anim",   int'(bus.animation_state), int'(m_anim));
    check("model.isplay", int'(bus.isplay), int'(m_vis));
    check("model.spawn",  int'(bus.barrel_spawn), int'(m_spawn));
    if (bus.barrel_spawn) spawn_seen++;
    if (int'(bus.posx) > posx_max) posx_max = int'(bus.posx);
    if (int'(bus.posx) > XMAX) out_of_range++;
    if (int'(bus.posx) == XMAX) hit_right = 1;
    if (hit_right && int'(bus.posx) < min_after_right) min_after_right = int'(bus.posx);
  endtask

  task automatic frame(input bit en, input bit pz, input bit kl);
    cyc(LINE, en, pz, kl);
    cyc(int'($urandom_range(0, LINE - 1)), en, pz, kl);
  endtask

  task automatic clear_stats();
    spawn_seen = 0; posx_max = 0; min_after_right = 1023; out_of_range = 0; hit_right = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int changes;
    int prev;
    bit en, pz, kl;
    int yv;

    tbl[0]  = '{478, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{479, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{0,   1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{0,   1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{479, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{479, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{100, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{479, 1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{5,   1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{479, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{6,   1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{479, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{7,   1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{479, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{8,   1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.y = '0; bus.enable = 1'b0; bus.pause = 1'b0; bus.kill = 1'b0;
    model_reset();
    clear_stats();
    repeat (3) @(negedge clk);

    check("reset.posx",   int'(bus.posx), 0);
    check("reset.posy",   int'(bus.posy), YPOS);
    check("reset.anim",   int'(bus.animation_state), 0);
    check("reset.isplay", int'(bus.isplay), 0);
    check("reset.spawn",  int'(bus.barrel_spawn), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].y, tbl[i].en, tbl[i].pz, tbl[i].kl);
      @(negedge clk);
      check($sformatf("vec%0d.posx", i),   int'(bus.posx), tbl[i].ex_posx);
      check($sformatf("vec%0d.isplay", i), int'(bus.isplay), int'(tbl[i].ex_vis));
      check($sformatf("vec%0d.anim", i),   int'(bus.animation_state), int'(tbl[i].ex_anim));
      check($sformatf("vec%0d.spawn", i),  int'(bus.barrel_spawn), int'(tbl[i].ex_spawn));
    end

    // Full scan-row sweep: exactly one frame tick.
    changes = 0;
    prev    = int'(bus.posx);
    for (int y = LINE; y >= 0; y--) begin
      cyc(y, 1'b1, 1'b0, 1'b0);
      if (int'(bus.posx) != prev) changes++;
      prev = int'(bus.posx);
    end
    check("sweep.ticks", changes, 1);
    check("sweep.posx", int'(bus.posx), 4);

    // Long patrol: bounce at both bounds, three full beats.
    cyc(0, 1'b1, 1'b0, 1'b1);
    clear_stats();
    repeat (700) frame(1'b1, 1'b0, 1'b0);
    check("patrol.spawns", spawn_seen, 3);
    check("patrol.posx_max", posx_max, XMAX);
    check("patrol.left_bound", min_after_right, 0);
    check("patrol.out_of_range", out_of_range, 0);

    // Pause freezes position, animation and counters.
    cyc(0, 1'b1, 1'b0, 1'b1);
    repeat (12) frame(1'b1, 1'b0, 1'b0);
    check("pause.pre_posx", int'(bus.posx), 24);
    check("pause.pre_anim", int'(bus.animation_state), 1);
    repeat (10) frame(1'b1, 1'b1, 1'b0);
    check("pause.held_posx", int'(bus.posx), 24);
    check("pause.held_anim", int'(bus.animation_state), 1);
    repeat (4) frame(1'b1, 1'b0, 1'b0);
    check("pause.resume_posx", int'(bus.posx), 32);
    check("pause.resume_anim", int'(bus.animation_state), 0);

    // Kill coincident with the final BEAT tick: no barrel spawn.
    cyc(0, 1'b1, 1'b0, 1'b1);
    repeat (179) frame(1'b1, 1'b0, 1'b0);
    check("killbeat.pre_posx", int'(bus.posx), 240);
    check("killbeat.pre_isplay", int'(bus.isplay), 1);
    cyc(LINE, 1'b1, 1'b0, 1'b0);
    cyc(3, 1'b1, 1'b0, 1'b1);
    check("killbeat.isplay", int'(bus.isplay), 0);
    check("killbeat.posx", int'(bus.posx), 0);
    check("killbeat.spawn", int'(bus.barrel_spawn), 0);
    cyc(4, 1'b1, 1'b0, 1'b0);
    check("killbeat.spawn_after", int'(bus.barrel_spawn), 0);

    // Random enable/pause/kill/scan-row traffic.
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      pz = ($urandom_range(0, 4) == 0);
      kl = ($urandom_range(0, 39) == 0);
      yv = ($urandom_range(0, 2) == 0) ? LINE : int'($urandom_range(0, LINE));
      cyc(yv, en, pz, kl);
    end

    // Asynchronous reset mid-walk.
    cyc(0, 1'b1, 1'b0, 1'b1);
    repeat (12) frame(1'b1, 1'b0, 1'b0);
    check("areset.pre_posx", int'(bus.posx), 24);
    check("areset.pre_anim", int'(bus.animation_state), 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset.posx",   int'(bus.posx), 0);
    check("areset.posy",   int'(bus.posy), YPOS);
    check("areset.anim",   int'(bus.animation_state), 0);
    check("areset.isplay", int'(bus.isplay), 0);
    check("areset.spawn",  int'(bus.barrel_spawn), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) frame(1'b1, 1'b0, 1'b0);
    check("areset.restart_posx", int'(bus.posx), 6);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
